// File: rtl/snn_infer_sequencer.sv
// Inference sequencer for the LIF SNN core: clear, T_STEPS gated frames, spike counting, argmax scan.
// Optional stall counter enabled by defining SNN_SEQ_STALL_CNT_EN.
module snn_infer_sequencer #(
    parameter int F       = 48,
    parameter int N       = 96,
    parameter int T_STEPS = 50,
    parameter int CNT_W   = 8,
    parameter int IDX_W   = $clog2(N)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [F-1:0]     in_events,
    output logic             core_clear,
    output logic             core_step,
    output logic [F-1:0]     core_event_vec,
    input  logic [N-1:0]     core_spikes,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [IDX_W-1:0] result_class,
    output logic [CNT_W-1:0] result_count,
    output logic [15:0]      result_total,
    output logic [15:0]      stall_cycles
);

    localparam int STEP_W = $clog2(T_STEPS + 1);
    localparam int PC_W   = $clog2(N + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_SCAN  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [STEP_W-1:0] STEP_TOTAL = STEP_W'(T_STEPS);
    localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(T_STEPS - 1);
    localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE    = IDX_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    function automatic logic [PC_W-1:0] popcount(input logic [N-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + PC_W'(v[i]);
        end
        return c;
    endfunction

    logic [2:0]        r_state;
    logic [STEP_W-1:0] r_step_cnt;
    logic              r_busy;
    logic              r_in_ready;
    logic              r_core_clear;
    logic              r_core_step;
    logic              r_spk_pending;
    logic              r_result_valid;
    logic [F-1:0]      r_core_event_vec;
    logic [CNT_W-1:0]  r_cnt [N];
    logic [IDX_W-1:0]  r_scan_idx;
    logic [IDX_W-1:0]  r_best_class;
    logic [CNT_W-1:0]  r_best_count;
    logic [15:0]       r_total;

    logic [2:0]        w_next_state;
    logic [STEP_W-1:0] w_step_cnt_next;
    logic              w_abort;
    logic              w_handshake;
    logic              w_capture;
    logic [16:0]       w_total_sum;

    assign w_abort     = abort && (r_state != S_IDLE);
    assign w_handshake = in_valid && r_in_ready;
    assign w_capture   = r_spk_pending && !w_abort;
    assign w_total_sum = {1'b0, r_total} + 17'(popcount(core_spikes));

    // Next-state selection; abort overrides every other transition.
    always_comb begin
        w_next_state = r_state;
        if (w_abort) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_next_state = start ? S_CLEAR : S_IDLE;
                S_CLEAR: w_next_state = S_RUN;
                S_RUN:   w_next_state = (w_handshake && (r_step_cnt == STEP_LAST)) ? S_DRAIN : S_RUN;
                // The final capture is the cycle whose spk_pending is not followed by another step.
                S_DRAIN: w_next_state = (r_spk_pending && !r_core_step) ? S_SCAN : S_DRAIN;
                S_SCAN:  w_next_state = (r_scan_idx == IDX_LAST) ? S_DONE : S_SCAN;
                S_DONE:  w_next_state = result_ready ? S_IDLE : S_DONE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Step counter next value: zeroed in CLEAR, advanced on each accepted frame.
    always_comb begin
        w_step_cnt_next = r_step_cnt;
        if (r_state == S_CLEAR) begin
            w_step_cnt_next = '0;
        end else if (w_handshake && !w_abort) begin
            w_step_cnt_next = r_step_cnt + STEP_ONE;
        end else begin
            w_step_cnt_next = r_step_cnt;
        end
    end

    // State, step count and registered handshake/strobe outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state          <= S_IDLE;
            r_step_cnt       <= '0;
            r_busy           <= 1'b0;
            r_in_ready       <= 1'b0;
            r_core_clear     <= 1'b0;
            r_core_step      <= 1'b0;
            r_spk_pending    <= 1'b0;
            r_result_valid   <= 1'b0;
            r_core_event_vec <= '0;
        end else begin
            r_state        <= w_next_state;
            r_step_cnt     <= w_step_cnt_next;
            r_busy         <= (w_next_state != S_IDLE);
            r_in_ready     <= (w_next_state == S_RUN) && (w_step_cnt_next != STEP_TOTAL);
            r_core_clear   <= (w_next_state == S_CLEAR);
            r_core_step    <= w_handshake && !w_abort;
            r_spk_pending  <= r_core_step && !w_abort;
            r_result_valid <= (w_next_state == S_DONE);
            if (w_handshake && !w_abort) begin
                r_core_event_vec <= in_events;
            end
        end
    end

    // Per-neuron saturating spike counters.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int n = 0; n < N; n++) begin
                r_cnt[n] <= '0;
            end
        end else if (r_state == S_CLEAR) begin
            for (int n = 0; n < N; n++) begin
                r_cnt[n] <= '0;
            end
        end else if (w_capture) begin
            for (int n = 0; n < N; n++) begin
                if (core_spikes[n] && (r_cnt[n] != CNT_MAX)) begin
                    r_cnt[n] <= r_cnt[n] + CNT_ONE;
                end
            end
        end
    end

    // Saturating total spike count across all neurons and steps.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_total <= 16'd0;
        end else if (r_state == S_CLEAR) begin
            r_total <= 16'd0;
        end else if (w_capture) begin
            r_total <= w_total_sum[16] ? 16'hFFFF : w_total_sum[15:0];
        end
    end

    // Sequential argmax; strict compare keeps the lowest index on ties.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_scan_idx   <= '0;
            r_best_class <= '0;
            r_best_count <= '0;
        end else if (r_state == S_CLEAR) begin
            r_scan_idx   <= '0;
            r_best_class <= '0;
            r_best_count <= '0;
        end else if (r_state == S_SCAN) begin
            r_scan_idx <= r_scan_idx + IDX_ONE;
            if (r_cnt[r_scan_idx] > r_best_count) begin
                r_best_class <= r_scan_idx;
                r_best_count <= r_cnt[r_scan_idx];
            end
        end
    end

`ifdef SNN_SEQ_STALL_CNT_EN
    logic [15:0] r_stall;

    // Counts RUN cycles where a frame was wanted but none was offered.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_stall <= 16'd0;
        end else if (r_state == S_CLEAR) begin
            r_stall <= 16'd0;
        end else if ((r_state == S_RUN) && r_in_ready && !in_valid && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign stall_cycles = r_stall;
`else
    assign stall_cycles = 16'd0;
`endif

    assign busy           = r_busy;
    assign in_ready       = r_in_ready;
    assign core_clear     = r_core_clear;
    assign core_step      = r_core_step;
    assign core_event_vec = r_core_event_vec;
    assign result_valid   = r_result_valid;
    assign result_class   = r_best_class;
    assign result_count   = r_best_count;
    assign result_total   = r_total;

endmodule

// File: tb/tb_snn_infer_sequencer.sv
// Bench for snn_infer_sequencer: two instances (T_STEPS=4/CNT_W=8 and T_STEPS=20/CNT_W=4), N=F=8.
module tb_snn_infer_sequencer;

    localparam int NN = 8;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic       sel, start, abort, in_valid, result_ready;
    logic [7:0] in_events;
    logic       a_start, b_start;
    assign a_start = start & ~sel;
    assign b_start = start & sel;

    logic        a_busy, a_in_ready, a_core_clear, a_core_step, a_result_valid;
    logic [7:0]  a_evec, a_spikes, a_count;
    logic [2:0]  a_class;
    logic [15:0] a_total, a_stall;
    logic        b_busy, b_in_ready, b_core_clear, b_core_step, b_result_valid;
    logic [7:0]  b_evec, b_spikes;
    logic [3:0]  b_count;
    logic [2:0]  b_class;
    logic [15:0] b_total, b_stall;

    snn_infer_sequencer #(.F(8), .N(8), .T_STEPS(4), .CNT_W(8)) u_a (
        .clk(clk), .rstn(rstn), .start(a_start), .abort(abort), .busy(a_busy),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_events(in_events),
        .core_clear(a_core_clear), .core_step(a_core_step), .core_event_vec(a_evec),
        .core_spikes(a_spikes), .result_valid(a_result_valid), .result_ready(result_ready),
        .result_class(a_class), .result_count(a_count), .result_total(a_total),
        .stall_cycles(a_stall)
    );

    snn_infer_sequencer #(.F(8), .N(8), .T_STEPS(20), .CNT_W(4)) u_b (
        .clk(clk), .rstn(rstn), .start(b_start), .abort(abort), .busy(b_busy),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_events(in_events),
        .core_clear(b_core_clear), .core_step(b_core_step), .core_event_vec(b_evec),
        .core_spikes(b_spikes), .result_valid(b_result_valid), .result_ready(result_ready),
        .result_class(b_class), .result_count(b_count), .result_total(b_total),
        .stall_cycles(b_stall)
    );

    // Core stand-in: one cycle after a step the spike vector equals the frame; otherwise junk.
    always @(posedge clk) begin
        a_spikes <= a_core_step ? a_evec : 8'($urandom);
        b_spikes <= b_core_step ? b_evec : 8'($urandom);
    end

    logic        v_busy, v_in_ready, v_core_clear, v_core_step, v_result_valid;
    logic [7:0]  v_evec, v_count;
    logic [2:0]  v_class;
    logic [15:0] v_total, v_stall;
    assign v_busy         = sel ? b_busy : a_busy;
    assign v_in_ready     = sel ? b_in_ready : a_in_ready;
    assign v_core_clear   = sel ? b_core_clear : a_core_clear;
    assign v_core_step    = sel ? b_core_step : a_core_step;
    assign v_result_valid = sel ? b_result_valid : a_result_valid;
    assign v_evec         = sel ? b_evec : a_evec;
    assign v_count        = sel ? {4'd0, b_count} : a_count;
    assign v_class        = sel ? b_class : a_class;
    assign v_total        = sel ? b_total : a_total;
    assign v_stall        = sel ? b_stall : a_stall;

    int step_total = 0;
    always @(negedge clk) begin
        if (v_core_step === 1'b1) step_total <= step_total + 1;
    end

    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0] cur_frames [0:19];
    int         cur_gap    [0:19];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // Reference: counts are frame-bit tallies (saturated); winner is the first maximum.
    function automatic void model(input int steps, input int cmax,
                                  output int cls, output int cnt, output int tot, output int stl);
        int c [NN];
        tot = 0; stl = 0; cls = 0; cnt = 0;
        for (int n = 0; n < NN; n++) c[n] = 0;
        for (int s = 0; s < steps; s++) begin
            stl += cur_gap[s];
            for (int n = 0; n < NN; n++) begin
                if (cur_frames[s][n]) begin
                    if (c[n] < cmax) c[n]++;
                    tot++;
                end
            end
        end
        if (tot > 65535) tot = 65535;
        for (int n = 0; n < NN; n++) begin
            if (c[n] > cnt) begin
                cnt = c[n];
                cls = n;
            end
        end
`ifndef SNN_SEQ_STALL_CNT_EN
        stl = 0;
`endif
    endfunction

    task automatic run_inference(input int steps, input string nm, input int ecls, input int ecnt,
                                 input int etot, input int estall, input int hold);
        int i, gap, guard, lat, s0;
        s0 = step_total;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({nm, ".clear"}, {31'd0, v_core_clear}, 32'd1);
        check({nm, ".busy"}, {31'd0, v_busy}, 32'd1);
        check({nm, ".rdy_early"}, {31'd0, v_in_ready}, 32'd0);
        @(negedge clk);
        check({nm, ".rdy"}, {31'd0, v_in_ready}, 32'd1);
        check({nm, ".clear_off"}, {31'd0, v_core_clear}, 32'd0);
        i = 0; gap = cur_gap[0]; guard = 0;
        while (i < steps && guard < 500) begin
            if (gap > 0) begin
                in_valid = 1'b0;
                gap--;
            end else begin
                in_valid  = 1'b1;
                in_events = cur_frames[i];
                if (v_in_ready === 1'b1) begin
                    i++;
                    if (i < steps) gap = cur_gap[i];
                end
            end
            guard++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check({nm, ".frames"}, i, steps);
        lat = 1;
        while (v_result_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({nm, ".latency"}, lat, NN + 3);
        check({nm, ".steps"}, step_total - s0, steps);
        check({nm, ".evec"}, {24'd0, v_evec}, {24'd0, cur_frames[steps-1]});
        check({nm, ".class"}, {29'd0, v_class}, ecls);
        check({nm, ".count"}, {24'd0, v_count}, ecnt);
        check({nm, ".total"}, {16'd0, v_total}, etot);
        check({nm, ".stall"}, {16'd0, v_stall}, estall);
        repeat (hold - 1) begin
            @(negedge clk);
            check({nm, ".hold_valid"}, {31'd0, v_result_valid}, 32'd1);
            check({nm, ".hold_class"}, {29'd0, v_class}, ecls);
        end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check({nm, ".valid_drop"}, {31'd0, v_result_valid}, 32'd0);
        check({nm, ".idle"}, {31'd0, v_busy}, 32'd0);
        check({nm, ".held_count"}, {24'd0, v_count}, ecnt);
        check({nm, ".held_total"}, {16'd0, v_total}, etot);
    endtask

    typedef struct {
        logic [31:0] frames;
        int          gap;
        int          ecls;
        int          ecnt;
        int          etot;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int cls, cnt, tot, stl, valid_seen;
        vecs[0] = '{32'h20202020, 0, 5, 4, 4};
        vecs[1] = '{32'h01848484, 0, 2, 3, 7};
        vecs[2] = '{32'h10101010, 10, 4, 4, 4};
        vecs[3] = '{32'h00000000, 0, 0, 0, 0};
        vecs[4] = '{32'h0000C0C0, 0, 6, 2, 4};

        sel = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        result_ready = 1'b0; in_events = 8'd0; rstn = 1'b0;
        for (int k = 0; k < 20; k++) begin cur_frames[k] = 8'd0; cur_gap[k] = 0; end

        repeat (3) @(negedge clk);
        check("rst.busy", {31'd0, a_busy}, 32'd0);
        check("rst.in_ready", {31'd0, a_in_ready}, 32'd0);
        check("rst.clear_step", {30'd0, a_core_clear, a_core_step}, 32'd0);
        check("rst.evec", {24'd0, a_evec}, 32'd0);
        check("rst.valid", {31'd0, a_result_valid}, 32'd0);
        check("rst.result", {21'd0, a_class, a_count}, 32'd0);
        check("rst.total_stall", {a_total, a_stall}, 32'd0);
        check("rst.b_outs", {b_busy, b_in_ready, b_core_clear, b_core_step, b_result_valid, 27'd0}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < 20; k++) cur_gap[k] = 0;
            for (int k = 0; k < 4; k++) cur_frames[k] = vecs[v].frames[8*k +: 8];
            cur_gap[2] = vecs[v].gap;
            model(4, 255, cls, cnt, tot, stl);
            run_inference(4, $sformatf("vec%0d", v), vecs[v].ecls, vecs[v].ecnt, vecs[v].etot, stl, 1);
        end

        // Abort after two accepted frames, then a clean inference must start from zero.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); in_valid = 1'b1; in_events = 8'hFF;
        @(negedge clk);
        @(negedge clk); in_valid = 1'b0; abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("abort.busy", {31'd0, v_busy}, 32'd0);
        check("abort.in_ready", {31'd0, v_in_ready}, 32'd0);
        check("abort.core_step", {31'd0, v_core_step}, 32'd0);
        valid_seen = 0;
        repeat (15) begin
            if (v_result_valid !== 1'b0) valid_seen++;
            @(negedge clk);
        end
        check("abort.no_result", valid_seen, 0);
        for (int k = 0; k < 20; k++) cur_gap[k] = 0;
        for (int k = 0; k < 4; k++) cur_frames[k] = 8'h20;
        run_inference(4, "post_abort", 5, 4, 4, 0, 1);

        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 20; k++) cur_gap[k] = 0;
            for (int k = 0; k < 4; k++) begin
                cur_frames[k] = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
                cur_gap[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            end
            model(4, 255, cls, cnt, tot, stl);
            run_inference(4, $sformatf("rnd%0d", r), cls, cnt, tot, stl, 1 + int'($urandom_range(0, 2)));
        end

        sel = 1'b1;
        for (int k = 0; k < 20; k++) begin cur_frames[k] = 8'h02; cur_gap[k] = 0; end
        run_inference(20, "sat", 1, 15, 20, 0, 5);
        sel = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/snn_infer_sequencer.md
Name: snn_infer_sequencer

Overview:
Inference controller for the Q1.14 LIF SNN core. It clears the core, feeds exactly T_STEPS event frames into it, and gates each time step with a step strobe. It accumulates per-neuron spike counts from the core's spike vector. At the end it scans those counts sequentially to produce an argmax class result through a valid/ready handshake. It sits between the event-frame source (upstream valid/ready) and the core instance.

Parameters:
F, 48, event features per frame (core input width)
N, 96, neurons (core output width)
T_STEPS, 50, time steps per inference (>=1)
CNT_W, 8, per-neuron spike counter width, saturating
IDX_W, $clog2(N), class index width

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
start  in  1  begin inference; sampled only in IDLE
abort  in  1  cancel inference; any state except IDLE
busy  out  1  high in every state except IDLE
in_valid  in  1  upstream event frame valid
in_ready  out  1  sequencer accepts frame
in_events  in  F  0/1 event frame
core_clear  out  1  one-cycle pulse; zeroes core V and refractory state
core_step  out  1  core advances exactly one time step on cycles where high
core_event_vec  out  F  frame presented to core, registered
core_spikes  in  N  core spike vector, valid the cycle after core_step
result_valid  out  1  result available
result_ready  in  1  downstream accepts result
result_class  out  IDX_W  argmax neuron index
result_count  out  CNT_W  spike count of winning neuron
result_total  out  16  total spikes across all neurons and steps, saturating at 65535
stall_cycles  out  16  RUN cycles with in_valid=0 (see Optional Feature)

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE. All outputs 0, including core_event_vec. Counters, step count and scan registers cleared.
- States: IDLE, CLEAR, RUN, DRAIN, SCAN, DONE.
- IDLE:
  - start=1 -> CLEAR.
  - start is ignored in every other state.
- CLEAR (1 cycle):
  - core_clear=1.
  - Spike counters, step count, result_total and stall_cycles zeroed.
  - Next state RUN.
- RUN:
  - in_ready=1 while step count < T_STEPS.
  - On a handshake at cycle k: core_event_vec<=in_events and core_step=1 at cycle k+1; step count increments.
  - core_step is low on every cycle without a preceding handshake; core_event_vec holds its last value.
  - After the T_STEPS-th handshake -> DRAIN, with in_ready=0 from the next cycle.
- Spike capture:
  - spk_pending is core_step delayed by one cycle.
  - On cycles with spk_pending=1, each counter[n] += core_spikes[n], saturating at 2^CNT_W-1.
  - result_total += popcount(core_spikes), saturating.
  - Capture overlaps with further RUN handshakes, so back-to-back frames give one step per cycle.
- DRAIN:
  - Wait until the final spk_pending capture is done -> SCAN.
  - Minimum DRAIN dwell is 2 cycles.
- SCAN:
  - N cycles, one neuron per cycle, index 0..N-1.
  - Replace the best candidate only if counter > best (strict). Ties therefore resolve to the lower index.
  - All-zero counts give class 0, count 0.
  - After index N-1 -> DONE.
- DONE:
  - result_valid=1; result_class, result_count and result_total are stable.
  - On result_valid && result_ready -> IDLE; result_valid drops the next cycle.
  - result_* hold their values until the next CLEAR.
- abort=1 in CLEAR, RUN, DRAIN, SCAN or DONE:
  - State -> IDLE at the next edge; in_ready, core_step and result_valid are 0 from the next cycle.
  - Any in-flight spike capture is discarded.
  - abort has priority over all other transitions.
- Latency: start-to-first in_ready is 2 cycles. From the last handshake to result_valid is 2 (DRAIN) + N (SCAN) + 1 cycles.

Optional Feature:
SNN_SEQ_STALL_CNT_EN
- Defined: stall_cycles increments (saturating at 65535) on each RUN cycle where in_ready=1 and in_valid=0. It is cleared in CLEAR and held in all other states.
- Undefined: stall_cycles is tied to 0 and no counter logic is synthesized.

Test Plan:
- Reset -> all outputs 0.
- start -> core_clear=1 at cycle 1; in_ready=1 at cycle 2.
- T_STEPS=4, N=8; core model spikes neuron 5 every step; frames back-to-back -> core_step high 4 consecutive cycles; result_class=5, result_count=4, result_total=4.
- T_STEPS=4; neurons 2 and 7 each spike 3 times, neuron 0 once -> result_class=2, result_count=3, result_total=7.
- T_STEPS=4; in_valid low for 10 cycles after the 2nd frame -> no core_step during the gap; exactly 4 core_step pulses total; stall_cycles=10 with the macro defined, 0 without.
- CNT_W=4, T_STEPS=20; neuron 1 always spikes -> result_count=15 (saturated), result_total=20; result_valid held for 5 cycles with result_ready=0, then one-cycle handshake -> IDLE.
- abort during RUN after the 2nd step -> busy=0 and in_ready=0 the next cycle, no result_valid. A following start clears all counters and gives a correct result.
